// File: rtl/spine_out_arbiter.sv
// Per-output-port packet arbiter for the spine router crossbar.
// Round-robin grant across NUM_REQ input ports, held for a whole packet until
// the tail flit, with one registered flit per cycle towards the output FIFO.
// Optional stall watchdog: define SPINE_ARB_WATCHDOG_EN to build it.
module spine_out_arbiter #(
  parameter int unsigned NUM_REQ = 11,
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned IDXW    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DWIDTH-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_fifo_full,
  output logic [NUM_REQ-1:0]        grant_onehot,
  output logic                      busy,
  output logic                      err_timeout
);

  // Elaboration-time parameter sanity checks.
  if ((1 << IDXW) < NUM_REQ) begin : g_bad_idxw
    $error("IDXW too narrow for NUM_REQ");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be non-zero");
  end

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e              state_q;
  logic [IDXW-1:0]     rr_ptr_q;
  logic [IDXW-1:0]     gnt_idx_q;
  logic [IDXW-1:0]     win_idx;
  logic [IDXW-1:0]     cand;
  logic [IDXW:0]       cand_sum;
  logic [IDXW-1:0]     next_ptr;
  logic                win_found;
  logic                xfer;
  logic                stall_hit;
  logic [DWIDTH-1:0]   gnt_data;

  // Round-robin pick: first set req bit scanning upward from rr_ptr_q, wrapping.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
      if (cand_sum >= (IDXW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDXW+1)'(NUM_REQ);
      end
      cand = cand_sum[IDXW-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Only the owner is offered ready; reset blocks acceptance in its own cycle.
  always_comb begin
    req_ready = '0;
    if (state_q == StLock && !out_fifo_full && !reset) begin
      req_ready[gnt_idx_q] = 1'b1;
    end
  end

  assign xfer     = (state_q == StLock) && req[gnt_idx_q] && !out_fifo_full && !reset;
  assign gnt_data = req_data[gnt_idx_q*DWIDTH +: DWIDTH];
  assign next_ptr = (gnt_idx_q == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
  assign busy     = (state_q == StLock);

`ifdef SPINE_ARB_WATCHDOG_EN
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  logic [StallW-1:0] stall_q;

  // Fires on the TIMEOUT-th consecutive LOCK cycle without a transfer.
  assign stall_hit = (state_q == StLock) && !xfer && (stall_q == StallW'(TIMEOUT - 1));

  // Stall counter: cleared in IDLE (so LOCK starts at 0) and on every transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == StIdle || xfer || stall_hit) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Arbiter FSM with registered flit, strobe, grant and timeout outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      gnt_idx_q    <= '0;
      grant_onehot <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      err_timeout  <= 1'b0;
    end else begin
      out_valid   <= xfer;
      err_timeout <= stall_hit;
      if (xfer) begin
        out_data <= gnt_data;
      end
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q      <= StLock;
            gnt_idx_q    <= win_idx;
            grant_onehot <= NUM_REQ'(1) << win_idx;
          end
        end
        StLock: begin
          if ((xfer && req_last[gnt_idx_q]) || stall_hit) begin
            state_q      <= StIdle;
            rr_ptr_q     <= next_ptr;
            grant_onehot <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spine_out_arbiter.sv
// Scoreboard bench for spine_out_arbiter: a packet-level reference model
// drives per-input flit sources, pushes expected flits into a queue, and a
// separate monitor pops and compares whenever out_valid is seen.
module tb_spine_out_arbiter;

  localparam int N  = 11;
  localparam int W  = 16;
  localparam int IW = 4;
  localparam int TO = 64;
  localparam int SD = 256;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_fifo_full;
  logic [N-1:0]     grant_onehot;
  logic             busy;
  logic             err_timeout;

  spine_out_arbiter #(
    .NUM_REQ (N),
    .DWIDTH  (W),
    .IDXW    (IW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_fifo_full (out_fifo_full),
    .grant_onehot  (grant_onehot),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  bit mon_en = 0;

  // Per-input flit sources (ring buffers).
  logic [W-1:0] sdata [N][SD];
  bit           slast [N][SD];
  int           head  [N];
  int           tail  [N];

  // Reference model: owner (-1 = idle), round-robin pointer, last-cycle transfer.
  int  m_owner;
  int  m_ptr;
  bit  m_prev_x;

  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every written flit must match the oldest expected flit.
  always @(negedge clk) begin
    if (mon_en && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_flit", {16'h0, out_data}, 32'hffff_ffff);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("out_data", {16'h0, out_data}, {16'h0, e});
      end
    end
  end

  task automatic push_pkt(input int i, input int len, input logic [W-1:0] base, input bit rnd);
    for (int f = 0; f < len; f++) begin
      sdata[i][tail[i] % SD] = rnd ? W'($urandom) : base + W'(f);
      slast[i][tail[i] % SD] = (f == len - 1);
      tail[i]++;
    end
  endtask

  function automatic int pending();
    int p;
    p = (m_owner >= 0) ? 1 : 0;
    for (int i = 0; i < N; i++) p += tail[i] - head[i];
    return p;
  endfunction

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic step(input bit full_v, input bit rst_v, input int gap_pct);
    logic [N-1:0] r;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_gnt;
    bit           x;
    for (int i = 0; i < N; i++) begin
      bit has;
      has = (head[i] != tail[i]);
      r[i] = has && (int'($urandom_range(99)) >= gap_pct);
      req_data[i*W +: W] = has ? sdata[i][head[i] % SD] : W'($urandom);
      req_last[i]        = has ? slast[i][head[i] % SD] : 1'($urandom);
    end
    req           = r;
    out_fifo_full = full_v;
    reset         = rst_v;

    exp_rdy = '0;
    exp_gnt = '0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    if (!rst_v && m_owner >= 0 && !full_v) exp_rdy[m_owner] = 1'b1;
    x = !rst_v && (m_owner >= 0) && r[m_owner] && !full_v;

    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("grant_onehot", 32'(grant_onehot), 32'(exp_gnt));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("out_valid", 32'(out_valid), 32'(m_prev_x));
    check("err_timeout", 32'(err_timeout), 32'h0);

    if (rst_v) begin
      m_owner = -1;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) head[i] = tail[i];
    end else if (x) begin
      exp_q.push_back(sdata[m_owner][head[m_owner] % SD]);
      if (slast[m_owner][head[m_owner] % SD]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
      head[(m_owner >= 0) ? m_owner : (m_ptr + N - 1) % N]++;
    end else if (m_owner < 0 && r != '0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (r[c]) begin
          m_owner = c;
          break;
        end
      end
    end
    m_prev_x = x;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max, input int gap_pct, input int full_pct);
    int cnt;
    cnt = 0;
    while (pending() != 0 && cnt < max) begin
      step(int'($urandom_range(99)) < full_pct, 1'b0, gap_pct);
      cnt++;
    end
    check("drain_bound", 32'(pending()), 32'h0);
    step(1'b0, 1'b0, 0);
  endtask

  initial begin
    reset         = 1'b1;
    req           = '0;
    req_data      = '0;
    req_last      = '0;
    out_fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    m_owner  = -1;
    m_ptr    = 0;
    m_prev_x = 0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1;

    // Idle after reset: everything stays low.
    repeat (10) step(1'b0, 1'b0, 0);

    // Single 3-flit packet from input 3.
    push_pkt(3, 3, 16'hA001, 0);
    drain(50, 0, 0);

    // Inputs 0, 5, 10 contend with single-flit packets.
    for (int p = 0; p < 2; p++) begin
      push_pkt(0, 1, 16'h0100 + 16'(p), 0);
      push_pkt(5, 1, 16'h0500 + 16'(p), 0);
      push_pkt(10, 1, 16'h0A00 + 16'(p), 0);
    end
    drain(50, 0, 0);

    // Owner 2 stalled by a full output FIFO mid-packet; input 7 waits.
    push_pkt(2, 4, 16'h2000, 0);
    push_pkt(7, 2, 16'h7000, 0);
    repeat (3) step(1'b0, 1'b0, 0);
    repeat (5) step(1'b1, 1'b0, 0);
    drain(50, 0, 0);

    // Reset in the middle of a 4-flit packet from input 6.
    push_pkt(6, 4, 16'h6000, 0);
    repeat (2) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    push_pkt(9, 2, 16'h9000, 0);
    push_pkt(4, 2, 16'h4000, 0);
    drain(50, 0, 0);

    // Randomized traffic with request gaps, backpressure and rare resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 30) begin
        int i;
        i = int'($urandom_range(N - 1));
        if (tail[i] - head[i] < 20) push_pkt(i, int'($urandom_range(4, 1)), 16'h0, 1);
      end
      step($urandom_range(99) < 20, $urandom_range(999) < 3, 15);
    end
    drain(2000, 10, 20);

    repeat (2) step(1'b0, 1'b0, 0);
    check("exp_left", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
